// File: rtl/mdr_seq_if.sv
// Handshake and data bundle between an operand source and the mdr_seq unit.
interface mdr_seq_if #(
    parameter int DW = 16
);
    logic            i_start;
    logic            i_load;
    logic [DW-1:0]   i_data;
    logic [1:0]      i_op;
    logic            o_ready;
    logic            o_load_x;
    logic            o_load_y;
    logic            o_done;
    logic            o_error;
    logic [2*DW-1:0] o_result;
    logic [DW-1:0]   o_remainder;

    modport master (
        output i_start, i_load, i_data, i_op,
        input  o_ready, o_load_x, o_load_y, o_done, o_error, o_result, o_remainder
    );

    modport slave (
        input  i_start, i_load, i_data, i_op,
        output o_ready, o_load_x, o_load_y, o_done, o_error, o_result, o_remainder
    );
endinterface

// File: rtl/mdr_seq.sv
// Sequential signed multiply / divide / square-root unit with serially loaded operands.
// One shared set of iteration registers (acc/b/m) serves all three iterative algorithms.
module mdr_seq #(
    parameter int DW = 16
) (
    input  logic     clk,
    input  logic     rst,
    mdr_seq_if.slave bus
);
    localparam int DW2 = 2 * DW;
    localparam int HW  = DW / 2;
    localparam int CW  = $clog2(DW + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_X = 3'd1;
    localparam logic [2:0] S_LOAD_Y = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_SQRT = 2'b10;

    localparam logic [DW-1:0]  ONE_DW    = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW2-1:0] ONE_DW2   = {{(DW2-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]  MIN_NEG   = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]  ALL_ONES  = {DW{1'b1}};
    localparam logic [CW-1:0]  ONE_CW    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]  LAST_FULL = CW'(DW - 1);
    localparam logic [CW-1:0]  LAST_HALF = CW'(HW - 1);

    function automatic logic [DW-1:0] neg_if(input logic c, input logic [DW-1:0] v);
        return c ? (~v + ONE_DW) : v;
    endfunction

    function automatic logic [DW2-1:0] neg_if2(input logic c, input logic [DW2-1:0] v);
        return c ? (~v + ONE_DW2) : v;
    endfunction

    logic [2:0]     state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [DW-1:0]  x_q, x_d, y_q, y_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW2-1:0] acc_q, acc_d, b_q, b_d;
    logic [DW-1:0]  m_q, m_d;
    logic           ready_q, ready_d, load_x_q, load_x_d, load_y_q, load_y_d;
    logic           done_q, done_d, error_q, error_d;
    logic [DW2-1:0] result_q, result_d;
    logic [DW-1:0]  rem_q, rem_d;

    logic           chk_err_s;
    logic           last_s;
    logic [DW2-1:0] it_acc_s, it_b_s;
    logic [DW-1:0]  it_m_s;
    logic [DW:0]    div_sh_s, div_d_s;
    logic [DW+1:0]  sq_rs_s, sq_trial_s;

    // Operand legality, evaluated while in CHECK.
    always_comb begin
        chk_err_s = 1'b0;
        case (op_q)
            OP_MUL:  chk_err_s = 1'b0;
            OP_DIV:  chk_err_s = (y_q == {DW{1'b0}}) || ((x_q == MIN_NEG) && (y_q == ALL_ONES));
            OP_SQRT: chk_err_s = x_q[DW-1];
            default: chk_err_s = 1'b1;
        endcase
    end

    // One iteration of the selected algorithm; m holds the shifting operand/quotient.
    always_comb begin
        it_acc_s   = acc_q;
        it_b_s     = b_q;
        it_m_s     = m_q;
        div_sh_s   = {acc_q[DW-1:0], m_q[DW-1]};
        div_d_s    = {1'b0, b_q[DW-1:0]};
        sq_rs_s    = {acc_q[DW-1:0], m_q[DW-1:DW-2]};
        sq_trial_s = {{(DW-HW){1'b0}}, b_q[HW-1:0], 2'b01};
        case (op_q)
            OP_MUL: begin
                it_acc_s = m_q[0] ? (acc_q + b_q) : acc_q;
                it_b_s   = {b_q[DW2-2:0], 1'b0};
                it_m_s   = {1'b0, m_q[DW-1:1]};
            end
            OP_DIV: begin
                // Partial remainder stays below the divisor, so DW bits always hold it.
                if (div_sh_s >= div_d_s) begin
                    it_acc_s = {{DW{1'b0}}, div_sh_s[DW-1:0] - div_d_s[DW-1:0]};
                    it_m_s   = {m_q[DW-2:0], 1'b1};
                end else begin
                    it_acc_s = {{DW{1'b0}}, div_sh_s[DW-1:0]};
                    it_m_s   = {m_q[DW-2:0], 1'b0};
                end
            end
            OP_SQRT: begin
                if (sq_rs_s >= sq_trial_s) begin
                    it_acc_s = {{(DW-2){1'b0}}, sq_rs_s - sq_trial_s};
                    it_b_s   = {{(DW2-HW){1'b0}}, b_q[HW-2:0], 1'b1};
                end else begin
                    it_acc_s = {{(DW-2){1'b0}}, sq_rs_s};
                    it_b_s   = {{(DW2-HW){1'b0}}, b_q[HW-2:0], 1'b0};
                end
                it_m_s = {m_q[DW-3:0], 2'b00};
            end
            default: begin
                it_acc_s = acc_q;
                it_b_s   = b_q;
                it_m_s   = m_q;
            end
        endcase
    end

    assign last_s = (cnt_q == ((op_q == OP_SQRT) ? LAST_HALF : LAST_FULL));

    // Sequencing, operand capture and result formatting.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        m_d      = m_q;
        error_d  = error_q;
        result_d = result_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_LOAD_X;
                    op_d    = bus.i_op;
                    error_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_X: begin
                if (bus.i_load) begin
                    x_d     = bus.i_data;
                    state_d = (op_q == OP_SQRT) ? S_CHECK : S_LOAD_Y;
                end else begin
                    state_d = S_LOAD_X;
                end
            end
            S_LOAD_Y: begin
                if (bus.i_load) begin
                    y_d     = bus.i_data;
                    state_d = S_CHECK;
                end else begin
                    state_d = S_LOAD_Y;
                end
            end
            S_CHECK: begin
                if (chk_err_s) begin
                    state_d  = S_DONE;
                    result_d = {DW2{1'b0}};
                    rem_d    = {DW{1'b0}};
                    error_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                    cnt_d   = {CW{1'b0}};
                    acc_d   = {DW2{1'b0}};
                    case (op_q)
                        OP_MUL: begin
                            b_d = {{DW{1'b0}}, neg_if(x_q[DW-1], x_q)};
                            m_d = neg_if(y_q[DW-1], y_q);
                        end
                        OP_DIV: begin
                            b_d = {{DW{1'b0}}, neg_if(y_q[DW-1], y_q)};
                            m_d = neg_if(x_q[DW-1], x_q);
                        end
                        default: begin
                            b_d = {DW2{1'b0}};
                            m_d = x_q;
                        end
                    endcase
                end
            end
            S_RUN: begin
                acc_d = it_acc_s;
                b_d   = it_b_s;
                m_d   = it_m_s;
                cnt_d = cnt_q + ONE_CW;
                if (last_s) begin
                    state_d = S_DONE;
                    case (op_q)
                        OP_MUL: begin
                            result_d = neg_if2(x_q[DW-1] ^ y_q[DW-1], it_acc_s);
                            rem_d    = {DW{1'b0}};
                        end
                        OP_DIV: begin
                            result_d = {{DW{result_sign(x_q[DW-1] ^ y_q[DW-1], it_m_s)}},
                                        neg_if(x_q[DW-1] ^ y_q[DW-1], it_m_s)};
                            rem_d    = neg_if(x_q[DW-1], it_acc_s[DW-1:0]);
                        end
                        default: begin
                            result_d = {{(DW2-HW){1'b0}}, it_b_s[HW-1:0]};
                            rem_d    = it_acc_s[DW-1:0];
                        end
                    endcase
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d  = (state_d == S_IDLE);
        load_x_d = (state_d == S_LOAD_X);
        load_y_d = (state_d == S_LOAD_Y);
        done_d   = (state_d == S_DONE);
    end

    function automatic logic result_sign(input logic c, input logic [DW-1:0] v);
        logic [DW-1:0] t;
        t = neg_if(c, v);
        return t[DW-1];
    endfunction

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            x_q      <= {DW{1'b0}};
            y_q      <= {DW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {DW2{1'b0}};
            b_q      <= {DW2{1'b0}};
            m_q      <= {DW{1'b0}};
            ready_q  <= 1'b1;
            load_x_q <= 1'b0;
            load_y_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= {DW2{1'b0}};
            rem_q    <= {DW{1'b0}};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            m_q      <= m_d;
            ready_q  <= ready_d;
            load_x_q <= load_x_d;
            load_y_q <= load_y_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
            rem_q    <= rem_d;
        end
    end

    assign bus.o_ready     = ready_q;
    assign bus.o_load_x    = load_x_q;
    assign bus.o_load_y    = load_y_q;
    assign bus.o_done      = done_q;
    assign bus.o_error     = error_q;
    assign bus.o_result    = result_q;
    assign bus.o_remainder = rem_q;
endmodule

// File: tb/tb_mdr_seq.sv
// Directed and randomized bench for mdr_seq against an integer-arithmetic reference model.
// Cycle j spans edges j-1..j, so a load at edge k gives o_done in the sample after edge k+1+N.
module tb_mdr_seq;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mdr_seq_if #(.DW(DW)) bus ();
    mdr_seq #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from signed integer arithmetic.
    task automatic model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] res, output logic [15:0] rem,
                         output logic err, output int lat);
        int     sx, sy, q, r;
        longint p;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        res = 32'h0;
        rem = 16'h0;
        err = 1'b0;
        lat = 2;
        case (op)
            2'b00: begin
                p   = longint'(sx) * longint'(sy);
                res = p[31:0];
                lat = DW + 2;
            end
            2'b01: begin
                if (sy == 0 || (sx == -32768 && sy == -1)) begin
                    err = 1'b1;
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = q;
                    rem = r[15:0];
                    lat = DW + 2;
                end
            end
            2'b10: begin
                if (sx < 0) begin
                    err = 1'b1;
                end else begin
                    r = 0;
                    while ((r + 1) * (r + 1) <= sx) r++;
                    q   = sx - r * r;
                    res = r;
                    rem = q[15:0];
                    lat = DW / 2 + 2;
                end
            end
            default: err = 1'b1;
        endcase
    endtask

    task automatic do_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                         input bit poke_start, input bit start_with_load);
        logic [31:0] eres;
        logic [15:0] erem;
        logic        eerr;
        int          elat, lat;
        bit          saw_y;
        model(op, x, y, eres, erem, eerr, elat);
        lat = 0;
        while (!bus.o_ready && lat < 100) begin
            tick();
            lat++;
        end
        check("ready_before_start", {31'h0, bus.o_ready}, 32'h1);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        if (start_with_load) begin
            bus.i_load = 1'b1;
            bus.i_data = 16'($urandom);
        end
        tick();
        bus.i_start = 1'b0;
        bus.i_load  = 1'b0;
        bus.i_op    = 2'($urandom);
        check("load_x_after_start", {31'h0, bus.o_load_x}, 32'h1);
        check("load_y_after_start", {31'h0, bus.o_load_y}, 32'h0);
        check("ready_low_busy", {31'h0, bus.o_ready}, 32'h0);
        check("error_clear_on_start", {31'h0, bus.o_error}, 32'h0);
        bus.i_data = x;
        bus.i_load = 1'b1;
        tick();
        bus.i_load = 1'b0;
        bus.i_data = 16'($urandom);
        check("load_x_fall", {31'h0, bus.o_load_x}, 32'h0);
        check("load_y_after_x", {31'h0, bus.o_load_y}, {31'h0, op != 2'b10});
        if (op != 2'b10) begin
            bus.i_data = y;
            bus.i_load = 1'b1;
            tick();
            bus.i_load = 1'b0;
            bus.i_data = 16'($urandom);
        end
        lat   = 1;
        saw_y = bus.o_load_y;
        while (!bus.o_done && lat < 100) begin
            bus.i_start = poke_start;
            bus.i_op    = 2'($urandom);
            tick();
            lat++;
            saw_y |= bus.o_load_y;
        end
        bus.i_start = 1'b0;
        check("done_latency", lat, elat);
        check("load_y_quiet", {31'h0, saw_y}, 32'h0);
        check("result", bus.o_result, eres);
        check("remainder", {16'h0, bus.o_remainder}, {16'h0, erem});
        check("error", {31'h0, bus.o_error}, {31'h0, eerr});
        tick();
        check("done_one_cycle", {31'h0, bus.o_done}, 32'h0);
        check("ready_after_done", {31'h0, bus.o_ready}, 32'h1);
        check("result_held", bus.o_result, eres);
        check("error_held", {31'h0, bus.o_error}, {31'h0, eerr});
    endtask

    initial begin
        bit          saw_done;
        logic [1:0]  rop;
        logic [15:0] rx, ry;
        bus.i_start = 1'b0;
        bus.i_load  = 1'b0;
        bus.i_data  = 16'h0;
        bus.i_op    = 2'b00;
        repeat (3) tick();
        check("rst_ready", {31'h0, bus.o_ready}, 32'h1);
        check("rst_load_x", {31'h0, bus.o_load_x}, 32'h0);
        check("rst_load_y", {31'h0, bus.o_load_y}, 32'h0);
        check("rst_done", {31'h0, bus.o_done}, 32'h0);
        check("rst_error", {31'h0, bus.o_error}, 32'h0);
        check("rst_result", bus.o_result, 32'h0);
        check("rst_remainder", {16'h0, bus.o_remainder}, 32'h0);
        rst = 1'b0;
        tick();

        do_op(2'b00, 16'hFFFD, 16'h0007, 1'b0, 1'b0);
        do_op(2'b01, 16'hFFF9, 16'h0002, 1'b0, 1'b0);
        do_op(2'b01, 16'h0007, 16'hFFFE, 1'b0, 1'b0);
        do_op(2'b10, 16'd50,   16'h0000, 1'b0, 1'b0);
        do_op(2'b00, 16'h8000, 16'h8000, 1'b0, 1'b0);
        do_op(2'b01, 16'h0005, 16'h0000, 1'b0, 1'b0);
        do_op(2'b01, 16'h8000, 16'hFFFF, 1'b0, 1'b0);
        do_op(2'b10, 16'hFFFC, 16'h0000, 1'b0, 1'b0);
        do_op(2'b11, 16'h0001, 16'h0002, 1'b0, 1'b0);
        do_op(2'b10, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
        do_op(2'b00, 16'h1234, 16'hFFB3, 1'b1, 1'b0);
        do_op(2'b01, 16'd1000, 16'd7,    1'b0, 1'b1);

        // Reset in the middle of a multiply.
        bus.i_start = 1'b1;
        bus.i_op    = 2'b00;
        tick();
        bus.i_start = 1'b0;
        bus.i_data  = 16'd300;
        bus.i_load  = 1'b1;
        tick();
        bus.i_data  = 16'hFFFB;
        tick();
        bus.i_load  = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrun_rst_ready", {31'h0, bus.o_ready}, 32'h1);
        check("midrun_rst_load_x", {31'h0, bus.o_load_x}, 32'h0);
        check("midrun_rst_load_y", {31'h0, bus.o_load_y}, 32'h0);
        check("midrun_rst_done", {31'h0, bus.o_done}, 32'h0);
        check("midrun_rst_error", {31'h0, bus.o_error}, 32'h0);
        check("midrun_rst_result", bus.o_result, 32'h0);
        check("midrun_rst_remainder", {16'h0, bus.o_remainder}, 32'h0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (25) begin
            tick();
            saw_done |= bus.o_done;
        end
        check("midrun_rst_no_done", {31'h0, saw_done}, 32'h0);
        check("midrun_rst_idle", {31'h0, bus.o_ready}, 32'h1);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ry = 16'h0000;
                1: begin rx = 16'h8000; ry = 16'hFFFF; end
                2: rx = 16'h8000;
                3: ry = 16'h0001;
                default: ;
            endcase
            do_op(rop, rx, ry, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
